// File: rtl/acc_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : acc_seq_pkg                                                   |
// | Purpose : Shared opcode constants, register-select constants and FSM    |
// |           state encoding for the accumulator sequencer.                 |
// | Revision: 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package acc_seq_pkg;

  localparam logic [2:0] OP_LDI = 3'b000;
  localparam logic [2:0] OP_MOV = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  localparam logic [1:0] REG_A   = 2'b00;
  localparam logic [1:0] REG_B   = 2'b01;
  localparam logic [1:0] REG_ACC = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  // Both 10 and 11 address the accumulator; fold them onto one code.
  function automatic logic [1:0] norm_reg(input logic [1:0] sel);
    case (sel)
      REG_A:   norm_reg = REG_A;
      REG_B:   norm_reg = REG_B;
      default: norm_reg = REG_ACC;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_alu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : acc_alu                                                       |
// | Purpose : Combinational ALU: result and carry/borrow from an opcode and |
// |           two operands. Arithmetic wraps modulo 2^DW.                   |
// | Ports   : op     - operation code                                      |
// |           a, b   - operands (a = rs1, b = rs2)                         |
// |           result - operation result                                    |
// |           carry  - ADD carry-out, SUB borrow (a < b), else 0           |
// | Revision: 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module acc_alu
  import acc_seq_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          carry
);

  logic [DW:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_MOV: result = a;
      OP_ADD: begin
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/acc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : acc_sequencer                                                 |
// | Purpose : Multi-cycle instruction sequencer driving an external A/B/ACC |
// |           register bank. Flow IDLE->READ->CAPT->EXEC->WRITE for ALU/MOV,|
// |           IDLE->WRITE for LDI/NOP.                                      |
// | Ports   : clk, rst           - clock, async active-high reset          |
// |           instr_*, opcode, rd, rs1, rs2, imm - instruction handshake   |
// |           rb_*               - register bank read selects/data, write  |
// |           done               - one-cycle retire pulse                  |
// |           flag_z, flag_c     - zero and carry/borrow flags             |
// | Revision: 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module acc_sequencer
  import acc_seq_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    opcode,
  input  logic [1:0]    rd,
  input  logic [1:0]    rs1,
  input  logic [1:0]    rs2,
  input  logic [DW-1:0] imm,
  output logic          rb_opwrite,
  output logic [1:0]    rb_reg_write,
  output logic [1:0]    rb_src_1,
  output logic [1:0]    rb_src_2,
  output logic [DW-1:0] rb_data,
  input  logic [DW-1:0] rb_data_src_1,
  input  logic [DW-1:0] rb_data_src_2,
  output logic          done,
  output logic          flag_z,
  output logic          flag_c
);

  state_t        state, state_nxt;
  logic [2:0]    op_q;
  logic [1:0]    rd_q, rs1_q, rs2_q;
  logic [DW-1:0] imm_q, opa_q, opb_q, res_q;
  logic          carry_q;
  logic [DW-1:0] alu_res;
  logic          alu_carry;
  logic [DW-1:0] wr_value;
  logic          accept;

  assign accept   = (state == ST_IDLE) && instr_valid;
  assign wr_value = (op_q == OP_LDI) ? imm_q : res_q;

  acc_alu #(.DW(DW)) u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .result (alu_res),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_NOP;
      rd_q    <= REG_A;
      rs1_q   <= REG_A;
      rs2_q   <= REG_A;
      imm_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= opcode;
        rd_q  <= norm_reg(rd);
        rs1_q <= rs1;
        rs2_q <= rs2;
        imm_q <= imm;
      end
      if (state == ST_CAPT) begin
        opa_q <= rb_data_src_1;
        opb_q <= rb_data_src_2;
      end
      if (state == ST_EXEC) begin
        res_q   <= alu_res;
        carry_q <= alu_carry;
      end
      // LDI never passes EXEC, so its carry_q is stale and must be masked.
      if (state == ST_WRITE && op_q != OP_NOP) begin
        flag_z <= (wr_value == '0);
        flag_c <= (op_q == OP_LDI) ? 1'b0 : carry_q;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    instr_ready  = 1'b0;
    rb_opwrite   = 1'b0;
    rb_reg_write = REG_A;
    rb_src_1     = REG_A;
    rb_src_2     = REG_A;
    rb_data      = '0;
    done         = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid)
          state_nxt = (opcode == OP_LDI || opcode == OP_NOP) ? ST_WRITE : ST_READ;
      end
      ST_READ: begin
        rb_src_1  = rs1_q;
        rb_src_2  = rs2_q;
        state_nxt = ST_CAPT;
      end
      ST_CAPT: begin
        rb_src_1  = rs1_q;
        rb_src_2  = rs2_q;
        state_nxt = ST_EXEC;
      end
      ST_EXEC:  state_nxt = ST_WRITE;
      ST_WRITE: begin
        rb_opwrite   = (op_q != OP_NOP);
        rb_reg_write = rd_q;
        rb_data      = wr_value;
        done         = 1'b1;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_acc_sequencer                                              |
// | Purpose : Directed self-checking bench for acc_sequencer with a model   |
// |           register bank and an expected-result queue.                   |
// | Revision: 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_acc_sequencer;
  import acc_seq_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    opcode;
  logic [1:0]    rd, rs1, rs2;
  logic [DW-1:0] imm;
  logic          rb_opwrite;
  logic [1:0]    rb_reg_write, rb_src_1, rb_src_2;
  logic [DW-1:0] rb_data, rb_data_src_1, rb_data_src_2;
  logic          done, flag_z, flag_c;

  always #5 clk = ~clk;

  acc_sequencer #(.DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .rd            (rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .imm           (imm),
    .rb_opwrite    (rb_opwrite),
    .rb_reg_write  (rb_reg_write),
    .rb_src_1      (rb_src_1),
    .rb_src_2      (rb_src_2),
    .rb_data       (rb_data),
    .rb_data_src_1 (rb_data_src_1),
    .rb_data_src_2 (rb_data_src_2),
    .done          (done),
    .flag_z        (flag_z),
    .flag_c        (flag_c)
  );

  function automatic int idx(input logic [1:0] sel);
    return sel[1] ? 2 : int'(sel);
  endfunction

  // Environment register bank, written only by the DUT.
  logic [DW-1:0] env_bank [0:2] = '{default: '0};
  int            write_count = 0;

  always_comb begin
    rb_data_src_1 = env_bank[idx(rb_src_1)];
    rb_data_src_2 = env_bank[idx(rb_src_2)];
  end

  always @(posedge clk) begin
    if (rb_opwrite) begin
      env_bank[idx(rb_reg_write)] <= rb_data;
      write_count <= write_count + 1;
    end
  end

  typedef struct {
    logic          ow;
    logic [1:0]    wr;
    logic [DW-1:0] data;
    logic          z;
    logic          c;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mbank [0:2];
  logic          mf_z, mf_c;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"},  instr_ready,  1);
    chk({tag, "_opw"},    rb_opwrite,   0);
    chk({tag, "_done"},   done,         0);
    chk({tag, "_wsel"},   rb_reg_write, 0);
    chk({tag, "_src1"},   rb_src_1,     0);
    chk({tag, "_src2"},   rb_src_2,     0);
    chk({tag, "_data"},   rb_data,      0);
    chk({tag, "_flag_z"}, flag_z,       0);
    chk({tag, "_flag_c"}, flag_c,       0);
  endtask

  // Called at a negedge; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s1,
                       input logic [1:0] s2, input logic [DW-1:0] im,
                       input bit push, input bit hold);
    exp_t          e;
    logic [DW-1:0] a, b, r;
    logic          c;
    int            n;
    instr_valid = 1'b1;
    opcode = op; rd = d; rs1 = s1; rs2 = s2; imm = im;
    a = mbank[idx(s1)];
    b = mbank[idx(s2)];
    r = '0;
    c = 1'b0;
    case (op)
      OP_LDI: r = im;
      OP_MOV: r = a;
      OP_ADD: {c, r} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin r = a - b; c = (a < b); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      default: ;
    endcase
    e.ow   = (op != OP_NOP);
    e.wr   = d[1] ? 2'b10 : d;
    e.data = r;
    e.z    = (op == OP_NOP) ? mf_z : (r == '0);
    e.c    = (op == OP_NOP) ? mf_c : c;
    e.lat  = (op == OP_LDI || op == OP_NOP) ? 1 : 4;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_at_issue", instr_ready, 1);
    if (push) begin
      sb.push_back(e);
      if (op != OP_NOP) begin
        mbank[idx(d)] = r;
        mf_z = e.z;
        mf_c = e.c;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic retire(input string tag, input logic [1:0] s1, input logic [1:0] s2);
    exp_t e;
    int   lat = 0, opw_bad = 0, src_bad = 0, rdy_low = 0;
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!instr_ready) rdy_low++;
      if (done) begin
        lat = i;
        break;
      end
      if (rb_opwrite) opw_bad++;
      if (e.lat == 4 && i <= 2 && (rb_src_1 !== s1 || rb_src_2 !== s2)) src_bad++;
    end
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_ready_low"}, rdy_low, e.lat);
    chk({tag, "_early_write"}, opw_bad, 0);
    chk({tag, "_opwrite"}, rb_opwrite, e.ow);
    if (e.ow) begin
      chk({tag, "_wsel"}, rb_reg_write, e.wr);
      chk({tag, "_data"}, rb_data, e.data);
    end
    if (e.lat == 4) chk({tag, "_src_sel"}, src_bad, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_ready_after"}, instr_ready, 1);
    chk({tag, "_flag_z"}, flag_z, e.z);
    chk({tag, "_flag_c"}, flag_c, e.c);
  endtask

  initial begin
    int wc0;
    rst = 1'b1;
    instr_valid = 1'b0;
    opcode = OP_NOP; rd = 2'b00; rs1 = 2'b00; rs2 = 2'b00; imm = '0;
    for (int i = 0; i < 3; i++) mbank[i] = '0;
    mf_z = 1'b0;
    mf_c = 1'b0;

    #12;
    reset_checks("reset");
    @(negedge clk);
    rst = 1'b0;

    issue(OP_LDI, REG_A, 2'b00, 2'b00, 32'd256, 1, 0);
    retire("ldi_a_256", 2'b00, 2'b00);
    issue(OP_LDI, REG_A, 2'b00, 2'b00, 32'hFFFF_FFFF, 1, 0);
    retire("ldi_a_max", 2'b00, 2'b00);
    issue(OP_LDI, REG_B, 2'b00, 2'b00, 32'd1, 1, 0);
    retire("ldi_b_1", 2'b00, 2'b00);

    // ADD with instr_valid kept high; the next instruction waits on the bus.
    issue(OP_ADD, REG_ACC, REG_A, REG_B, '0, 1, 1);
    opcode = OP_LDI; rd = REG_B; imm = 32'd5;
    retire("add_wrap", REG_A, REG_B);
    issue(OP_LDI, REG_B, 2'b00, 2'b00, 32'd5, 1, 0);
    retire("held_ldi_b_5", 2'b00, 2'b00);

    issue(OP_LDI, REG_A, 2'b00, 2'b00, 32'd7, 1, 0);
    retire("ldi_a_7", 2'b00, 2'b00);
    issue(OP_SUB, REG_B, REG_B, REG_A, '0, 1, 0);
    retire("sub_borrow", REG_B, REG_A);
    issue(OP_NOP, REG_A, 2'b00, 2'b00, '0, 1, 0);
    retire("nop", 2'b00, 2'b00);
    issue(OP_MOV, 2'b11, REG_B, 2'b00, '0, 1, 0);
    retire("mov_acc11", REG_B, 2'b00);
    issue(OP_AND, REG_A, 2'b11, REG_A, '0, 1, 0);
    retire("and", 2'b11, REG_A);
    issue(OP_OR, REG_B, REG_A, REG_A, '0, 1, 0);
    retire("or_same_src", REG_A, REG_A);
    issue(OP_ADD, REG_ACC, REG_ACC, REG_B, '0, 1, 0);
    retire("add_carry", REG_ACC, REG_B);

    // Abort an XOR with reset while it sits in EXEC.
    issue(OP_XOR, REG_A, REG_A, REG_B, '0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    wc0 = write_count;
    rst = 1'b1;
    #1;
    reset_checks("abort_in_rst");
    @(negedge clk);
    rst = 1'b0;
    mf_z = 1'b0;
    mf_c = 1'b0;
    #1;
    reset_checks("abort_after");
    repeat (4) @(negedge clk);
    chk("abort_no_write", write_count, wc0);

    issue(OP_LDI, REG_ACC, 2'b00, 2'b00, 32'h1234_5678, 1, 0);
    retire("ldi_after_abort", 2'b00, 2'b00);
    issue(OP_XOR, REG_A, 2'b11, REG_B, '0, 1, 0);
    retire("xor", 2'b11, REG_B);
    issue(OP_SUB, REG_A, REG_B, REG_B, '0, 1, 0);
    retire("sub_zero", REG_B, REG_B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 Parameter: DW, 32, data width of register bank and immediate.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  sequencer can accept an instruction.
REQ-006 opcode  input  3  operation code.
REQ-007 rd  input  2  destination register (00 A, 01 B, 1x ACC).
REQ-008 rs1, rs2  input  2 each  source register selects.
REQ-009 imm  input  DW  immediate for LDI.
REQ-010 rb_opwrite  output  1  register-bank write enable.
REQ-011 rb_reg_write  output  2  register-bank write select.
REQ-012 rb_src_1, rb_src_2  output  2 each  register-bank read selects.
REQ-013 rb_data  output  DW  register-bank write data.
REQ-014 rb_data_src_1, rb_data_src_2  input  DW each  register-bank read data.
REQ-015 done  output  1  one-cycle pulse, instruction retired.
REQ-016 flag_z, flag_c  output  1 each  zero and carry/borrow flags.

Function
REQ-017 Opcodes SHALL be: 000 LDI rd=imm; 001 MOV rd=rs1; 010 ADD rd=rs1+rs2; 011 SUB rd=rs1-rs2; 100 AND; 101 OR; 110 XOR; 111 NOP.
REQ-018 FSM states SHALL be IDLE, READ, CAPT, EXEC, WRITE.
REQ-019 instr_ready SHALL be 1 only in IDLE; handshake = instr_valid & instr_ready at a rising edge; opcode/rd/rs1/rs2/imm latched then.
REQ-020 instr_valid outside IDLE SHALL be ignored; inputs may change freely without effect.
REQ-021 Transitions: IDLE->READ for opcodes 001-110; IDLE->WRITE for LDI and NOP; READ->CAPT->EXEC->WRITE->IDLE, one cycle each.
REQ-022 READ, CAPT: rb_opwrite=0, rb_src_1=rs1, rb_src_2=rs2 held stable; operands registered at CAPT->EXEC edge.
REQ-023 EXEC: result and flags computed and registered at EXEC->WRITE edge.
REQ-024 WRITE: rb_opwrite=1 (0 for NOP), rb_reg_write=rd, rb_data=result (imm for LDI), held the full cycle; done=1.
REQ-025 Latency: ALU/MOV accepted at edge t0 -> WRITE/done in cycle t3..t4, instr_ready high after t4; LDI/NOP -> WRITE in cycle t0..t1.
REQ-026 Arithmetic SHALL be modulo 2^DW; ADD flag_c = carry-out; SUB flag_c = 1 when rs1 < rs2 unsigned; logic ops and MOV/LDI clear flag_c.
REQ-027 flag_z SHALL be 1 iff written value is zero; flags update at WRITE->IDLE edge, unchanged by NOP.
REQ-028 rd=11 and rd=10 SHALL both target ACC; rs1=rs2 permitted.
REQ-029 rb_opwrite SHALL be 0 in every state except WRITE.

Reset
REQ-030 RST=1 SHALL immediately force state IDLE, instr_ready=1, rb_opwrite=0, done=0, rb_reg_write/rb_src_1/rb_src_2=00, rb_data=0, flags=0.
REQ-031 RST asserted mid-instruction SHALL abort it with no register write; first instruction accepted at first rising edge after deassertion.

Structure
REQ-032 Shared package acc_seq_pkg SHALL hold opcode constants, state encoding and register-select constants (REG_A, REG_B, REG_ACC).
REQ-033 One combinational sub-module acc_alu SHALL compute result and carry from opcode and two operands.

Verification
REQ-034 Reset then LDI rd=00 imm=256 -> WRITE cycle rb_opwrite=1, rb_reg_write=00, rb_data=256, done=1, flag_z=0.
REQ-035 ADD rs1=A(0xFFFFFFFF) rs2=B(1) rd=ACC -> rb_data=0, flag_z=1, flag_c=1, done exactly 4 cycles after accept.
REQ-036 SUB rs1=B(5) rs2=A(7) rd=B -> rb_data=0xFFFFFFFE, flag_c=1; rb_src_1=01, rb_src_2=00 during READ/CAPT.
REQ-037 instr_valid held high during ADD -> second instruction accepted only on edge after WRITE; instr_ready low 4 cycles.
REQ-038 RST pulse during EXEC of XOR -> rb_opwrite never 1, outputs at reset values, following LDI executes normally.
REQ-039 NOP -> done pulse one cycle after accept, rb_opwrite stays 0, flags unchanged.
